// File: rtl/rgb_fade_pkg.sv
// rgb_fade_pkg: FSM state type and colour-wheel keyframe table for rgb_fade_sequencer.
package rgb_fade_pkg;

    typedef enum logic [1:0] {IDLE, FADE, HOLD} state_t;

    localparam int NUM_PHASES = 6;

    // {r,g,b} full-on mask per keyframe, wheel order R,Y,G,C,B,M
    function automatic logic [2:0] key_mask(input logic [2:0] phase);
        return phase == 3'd0 ? 3'b100 :
               phase == 3'd1 ? 3'b110 :
               phase == 3'd2 ? 3'b010 :
               phase == 3'd3 ? 3'b011 :
               phase == 3'd4 ? 3'b001 :
               phase == 3'd5 ? 3'b101 : 3'b000;
    endfunction

endpackage

// File: rtl/rgb_fade_sequencer_if.sv
// rgb_fade_sequencer_if: control inputs and PWM duty outputs of the fade sequencer.
interface rgb_fade_sequencer_if #(parameter int WIDTH = 8);

    logic             ena;
    logic             auto_en;
    logic             pwm_sync;
    logic [WIDTH-1:0] man_r, man_g, man_b;
    logic [WIDTH-1:0] duty_r, duty_g, duty_b;
    logic [2:0]       phase;
    logic             busy;

    modport master (
        output ena, auto_en, pwm_sync, man_r, man_g, man_b,
        input  duty_r, duty_g, duty_b, phase, busy
    );

    modport slave (
        input  ena, auto_en, pwm_sync, man_r, man_g, man_b,
        output duty_r, duty_g, duty_b, phase, busy
    );

endinterface

// File: rtl/rgb_fade_sequencer_channel.sv
// fade_channel: one colour level register that loads a manual value or steps toward a target.
module fade_channel #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] man,
    input  logic             step_en,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] lvl,
    output logic             at_target
);

    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

    logic [WIDTH:0]   up, dn;
    logic [WIDTH-1:0] nxt;

    // Extra bit catches both carry past MAX and borrow below zero, so the step clamps at target
    always_comb begin
        up  = {1'b0, lvl} + STEP_W;
        dn  = {1'b0, lvl} - STEP_W;
        nxt = lvl < target ? (up >= {1'b0, target} ? target : up[WIDTH-1:0])
                           : (dn[WIDTH] || dn[WIDTH-1:0] <= target ? target : dn[WIDTH-1:0]);
    end

    // Reports the post-step value so the FSM can leave FADE on the very tick that lands
    assign at_target = nxt == target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lvl <= '0;
        else if (load)
            lvl <= man;
        else if (step_en)
            lvl <= nxt;
    end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: manual/auto colour-wheel controller feeding three PWM duty registers.
// Optional square-law gamma on the duty path when RGB_FADE_GAMMA_EN is defined.
module rgb_fade_sequencer
    import rgb_fade_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TICK_DIV   = 1024,
    parameter int HOLD_TICKS = 64,
    parameter int STEP       = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    rgb_fade_sequencer_if.slave bus
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    state_t           state;
    logic [TW-1:0]    tick_cnt;
    logic [HW-1:0]    hold_cnt;
    logic [2:0]       phase;
    logic             busy;
    logic             tick, load, step_en;
    logic [2:0]       mask, at;
    logic [WIDTH-1:0] lvl  [3];
    logic [WIDTH-1:0] duty [3];

    function automatic logic [WIDTH-1:0] gamma(input logic [WIDTH-1:0] x);
`ifdef RGB_FADE_GAMMA_EN
        logic [2*WIDTH-1:0] p;
        p = {{WIDTH{1'b0}}, x} * ({{WIDTH{1'b0}}, x} + 1'b1);
        return p[2*WIDTH-1:WIDTH];
`else
        return x;
`endif
    endfunction

    assign tick    = bus.ena && state != IDLE && tick_cnt == TW'(TICK_DIV - 1);
    assign load    = bus.ena && state == IDLE;
    assign step_en = tick && bus.auto_en && state == FADE;
    assign mask    = key_mask(phase);

    for (genvar c = 0; c < 3; c++) begin : g_ch
        fade_channel #(.WIDTH(WIDTH), .STEP(STEP)) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load),
            .man       (c == 0 ? bus.man_r : c == 1 ? bus.man_g : bus.man_b),
            .step_en   (step_en),
            .target    ({WIDTH{mask[2-c]}}),
            .lvl       (lvl[c]),
            .at_target (at[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            phase    <= '0;
            tick_cnt <= '0;
            hold_cnt <= '0;
            busy     <= 1'b0;
        end else if (bus.ena) begin
            if (!bus.auto_en) begin
                state    <= IDLE;
                phase    <= '0;
                tick_cnt <= '0;
                hold_cnt <= '0;
                busy     <= 1'b0;
            end else if (state == IDLE) begin
                state    <= FADE;
                phase    <= '0;
                tick_cnt <= '0;
                busy     <= 1'b1;
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                if (tick && state == FADE && &at) begin
                    state    <= HOLD;
                    hold_cnt <= '0;
                    busy     <= 1'b0;
                end
                if (tick && state == HOLD) begin
                    if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
                        state <= FADE;
                        busy  <= 1'b1;
                        phase <= phase == 3'(NUM_PHASES - 1) ? '0 : phase + 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Captures pre-edge levels, so a tick on a sync cycle shows up one PWM period later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            duty <= '{default: '0};
        else if (bus.pwm_sync)
            duty <= '{gamma(lvl[0]), gamma(lvl[1]), gamma(lvl[2])};
    end

    assign bus.duty_r = duty[0];
    assign bus.duty_g = duty[1];
    assign bus.duty_b = duty[2];
    assign bus.phase  = phase;
    assign bus.busy   = busy;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb_rgb_fade_sequencer: directed and randomized checks against a keyframe-wheel reference model.
module tb_rgb_fade_sequencer;

    localparam int W  = 8;
    localparam int TD = 4;
    localparam int HT = 2;
    localparam int ST = 64;
    localparam int M_IDLE = 0, M_FADE = 1, M_HOLD = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rgb_fade_sequencer_if #(.WIDTH(W)) bus();

    rgb_fade_sequencer #(.WIDTH(W), .TICK_DIV(TD), .HOLD_TICKS(HT), .STEP(ST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    int keys [6][3] = '{'{255,0,0}, '{255,255,0}, '{0,255,0}, '{0,255,255}, '{0,0,255}, '{255,0,255}};
    int m_mode, m_phase, m_tick, m_hold;
    int m_lvl [3];
    int m_duty [3];

    function automatic int f(input int x);
`ifdef RGB_FADE_GAMMA_EN
        return (x * (x + 1)) >> W;
`else
        return x;
`endif
    endfunction

    function automatic int approach(input int l, input int t);
        return l < t ? ((l + ST > t) ? t : l + ST) : ((l - ST < t) ? t : l - ST);
    endfunction

    function automatic int man_of(input int c);
        return c == 0 ? int'(bus.man_r) : c == 1 ? int'(bus.man_g) : int'(bus.man_b);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_phase = 0; m_tick = 0; m_hold = 0;
        for (int c = 0; c < 3; c++) begin m_lvl[c] = 0; m_duty[c] = 0; end
    endtask

    task automatic model_edge();
        int old_mode;
        bit done;
        old_mode = m_mode;
        if (bus.pwm_sync) for (int c = 0; c < 3; c++) m_duty[c] = f(m_lvl[c]);
        if (bus.ena) begin
            if (old_mode == M_IDLE) for (int c = 0; c < 3; c++) m_lvl[c] = man_of(c);
            if (!bus.auto_en) begin
                m_mode = M_IDLE; m_phase = 0; m_tick = 0; m_hold = 0;
            end else if (old_mode == M_IDLE) begin
                m_mode = M_FADE; m_phase = 0; m_tick = 0;
            end else if (++m_tick == TD) begin
                m_tick = 0;
                if (m_mode == M_FADE) begin
                    done = 1;
                    for (int c = 0; c < 3; c++) begin
                        m_lvl[c] = approach(m_lvl[c], keys[m_phase][c]);
                        if (m_lvl[c] != keys[m_phase][c]) done = 0;
                    end
                    if (done) begin m_mode = M_HOLD; m_hold = 0; end
                end else if (++m_hold == HT) begin
                    m_phase = (m_phase + 1) % 6;
                    m_mode = M_FADE;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("duty_r", bus.duty_r, m_duty[0]);
        chk("duty_g", bus.duty_g, m_duty[1]);
        chk("duty_b", bus.duty_b, m_duty[2]);
        chk("phase", bus.phase, m_phase);
        chk("busy", bus.busy, m_mode == M_FADE);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [W-1:0] prev_r, prev_g, prev_b, sr, sg, sb;
        logic [2:0]   sp;
        int           bq [$];
        int           n;
        bus.ena = 1'b1; bus.auto_en = 1'b0; bus.pwm_sync = 1'b1;
        bus.man_r = 8'd10; bus.man_g = 8'd20; bus.man_b = 8'd30;
        model_reset();
        @(negedge clk);
        chk("rst_duty_r", bus.duty_r, 0);
        chk("rst_duty_b", bus.duty_b, 0);
        chk("rst_phase", bus.phase, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        cycle(); cycle();
        chk("man_r", bus.duty_r, f(10));
        chk("man_g", bus.duty_g, f(20));
        chk("man_b", bus.duty_b, f(30));
        chk("man_busy", bus.busy, 0);
        // first fade from black toward red
        bus.man_r = 8'd0; bus.man_g = 8'd0; bus.man_b = 8'd0;
        cycle(); cycle();
        bus.auto_en = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            cycle();
            if (k == 5) chk("fade_busy", bus.busy, 1);
            if (k == 6) chk("r_64", bus.duty_r, f(64));
            if (k == 10) chk("r_128", bus.duty_r, f(128));
            if (k == 14) chk("r_192", bus.duty_r, f(192));
            if (k == 18) chk("r_255", bus.duty_r, f(255));
            if (k >= 17 && k <= 24) chk("hold_busy", bus.busy, 0);
            if (k == 24) chk("hold_phase0", bus.phase, 0);
            if (k == 25) chk("phase1", bus.phase, 1);
        end
        // run around to magenta and through its hold
        n = 0;
        while (n < 2000 && !(m_phase == 5 && m_mode == M_HOLD)) begin cycle(); n++; end
        chk("p5_phase", bus.phase, 5);
        chk("p5_busy", bus.busy, 0);
        n = 0;
        while (n < 100 && bus.phase != 3'd0) begin cycle(); n++; end
        chk("wrap_phase", bus.phase, 0);
        prev_b = bus.duty_b;
        for (int k = 0; k < 40; k++) begin
            cycle();
            chk("wrap_r_hold", bus.duty_r, f(255));
            if (bus.duty_b != prev_b) bq.push_back(int'(bus.duty_b));
            prev_b = bus.duty_b;
        end
        chk("b_steps", bq.size(), 4);
        if (bq.size() == 4) begin
            chk("b_191", bq[0], f(191));
            chk("b_127", bq[1], f(127));
            chk("b_63", bq[2], f(63));
            chk("b_0", bq[3], f(0));
        end
        // sparse pwm_sync: duty may only move on cycles carrying a sync
        for (int k = 0; k < 160; k++) begin
            bus.pwm_sync = (k % 16 == 0);
            prev_r = bus.duty_r; prev_g = bus.duty_g; prev_b = bus.duty_b;
            cycle();
            if (!bus.pwm_sync) begin
                chk("nosync_r", bus.duty_r, prev_r);
                chk("nosync_g", bus.duty_g, prev_g);
                chk("nosync_b", bus.duty_b, prev_b);
            end
        end
        bus.pwm_sync = 1'b1;
        // freeze mid-fade
        n = 0;
        while (n < 200 && !(m_mode == M_FADE && m_tick == 1)) begin cycle(); n++; end
        chk("pre_freeze_busy", bus.busy, 1);
        bus.ena = 1'b0;
        cycle();
        sr = bus.duty_r; sg = bus.duty_g; sb = bus.duty_b; sp = bus.phase;
        for (int k = 0; k < 19; k++) cycle();
        chk("frz_r", bus.duty_r, sr);
        chk("frz_g", bus.duty_g, sg);
        chk("frz_b", bus.duty_b, sb);
        chk("frz_phase", bus.phase, sp);
        chk("frz_busy", bus.busy, 1);
        bus.ena = 1'b1;
        for (int k = 0; k < 30; k++) cycle();
        // drop to manual mid-fade
        n = 0;
        while (n < 200 && m_mode != M_FADE) begin cycle(); n++; end
        bus.auto_en = 1'b0;
        bus.man_r = 8'($urandom_range(0, 255));
        bus.man_g = 8'($urandom_range(0, 255));
        bus.man_b = 8'($urandom_range(0, 255));
        cycle();
        chk("abort_busy", bus.busy, 0);
        chk("abort_phase", bus.phase, 0);
        cycle(); cycle();
        chk("abort_man_r", bus.duty_r, f(int'(bus.man_r)));
        chk("abort_man_g", bus.duty_g, f(int'(bus.man_g)));
        chk("abort_man_b", bus.duty_b, f(int'(bus.man_b)));
        bus.man_r = 8'd128; bus.man_g = 8'd255; bus.man_b = 8'd0;
        cycle(); cycle(); cycle();
`ifdef RGB_FADE_GAMMA_EN
        chk("gamma_128", bus.duty_r, 64);
`else
        chk("lin_128", bus.duty_r, 128);
`endif
        chk("curve_255", bus.duty_g, 255);
        // asynchronous reset while holding
        bus.auto_en = 1'b1;
        n = 0;
        while (n < 200 && !(m_mode == M_HOLD && m_phase > 0)) begin cycle(); n++; end
        chk("pre_rst_busy", bus.busy, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_r", bus.duty_r, 0);
        chk("arst_g", bus.duty_g, 0);
        chk("arst_phase", bus.phase, 0);
        chk("arst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            bus.ena = $urandom_range(0, 9) != 0;
            bus.pwm_sync = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 99) == 0) bus.auto_en = ~bus.auto_en;
            bus.man_r = 8'($urandom_range(0, 255));
            bus.man_g = 8'($urandom_range(0, 255));
            bus.man_b = 8'($urandom_range(0, 255));
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
